xmuladdlite_seq: RTL and testbench

//  Sequencer for one muladdlite MAC unit. Buffers up to DEPTH configuration words in a FIFO.
//  On a go pulse it issues the words back-to-back:
//   - presents each word on mac_conf;
//   - pulses mac_init;
//   - times the run from the word's iterations/period/delay fields plus pipeline drain;
//   - signals done when the queue is exhausted.

---
 rtl/xmuladdlite_seq.sv | 165 ++++++++++++++++
 tb/tb_xmuladdlite_seq.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/xmuladdlite_seq.sv
// Sequencer for one muladdlite MAC: queues configuration words and issues them
// one at a time (conf, init pulse, timed run, pipeline drain), then signals done.
module xmuladdlite_seq #(
  parameter int unsigned N_W        = 5,
  parameter int unsigned MEM_ADDR_W = 10,
  parameter int unsigned PERIOD_W   = 5,
  parameter int unsigned SHIFT_W    = 5,
  parameter int unsigned CONF_W     = 3*N_W + MEM_ADDR_W + 2*PERIOD_W + SHIFT_W + 3,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned PIPE_LAT   = 6
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cfg_valid,
  output logic                         cfg_ready,
  input  logic [CONF_W-1:0]            cfg_data,
  input  logic                         go,
  output logic [CONF_W-1:0]            mac_conf,
  output logic                         mac_init,
  output logic                         mac_addrgen_rst,
  output logic                         busy,
  output logic                         done,
  output logic [$clog2(DEPTH+1)-1:0]   n_pending
);

  localparam int unsigned PTR_W     = $clog2(DEPTH);
  localparam int unsigned CNT_W     = $clog2(DEPTH+1);
  localparam int unsigned RUN_W     = MEM_ADDR_W + PERIOD_W + 1;
  localparam int unsigned DELAY_LSB = SHIFT_W + 3;
  localparam int unsigned PER_LSB   = DELAY_LSB + PERIOD_W;
  localparam int unsigned ITER_LSB  = PER_LSB + PERIOD_W;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_INIT  = 3'd2,
    S_RUN   = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic [CONF_W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [CNT_W-1:0]      count_nxt;
  logic                  push_c, pop_c, fifo_empty_c;

  logic [RUN_W-1:0]      cnt;
  logic [RUN_W-1:0]      run_len_c;
  logic [MEM_ADDR_W-1:0] cur_iter_c;
  logic [PERIOD_W-1:0]   cur_period_c, cur_delay_c, per_eff_c;
  logic                  cnt_last_c;

  logic                  mac_init_nxt, addrgen_rst_nxt, busy_nxt, done_nxt;

  // Fields of the word currently held on mac_conf
  assign cur_iter_c   = mac_conf[ITER_LSB +: MEM_ADDR_W];
  assign cur_period_c = mac_conf[PER_LSB  +: PERIOD_W];
  assign cur_delay_c  = mac_conf[DELAY_LSB +: PERIOD_W];
  assign per_eff_c    = (cur_period_c == '0) ? PERIOD_W'(1) : cur_period_c;
  assign run_len_c    = RUN_W'(cur_delay_c) + RUN_W'(cur_iter_c) * RUN_W'(per_eff_c);
  assign cnt_last_c   = (cnt == RUN_W'(1));

  assign fifo_empty_c = (n_pending == '0);
  assign push_c       = cfg_valid & cfg_ready;
  // The head is popped on the edge that enters LOAD, so mac_conf is valid during LOAD
  assign pop_c        = (state_nxt == S_LOAD);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (go && !fifo_empty_c) state_nxt = S_LOAD;
      S_LOAD: begin
        if (cur_iter_c != '0)   state_nxt = S_INIT;
        else if (!fifo_empty_c) state_nxt = S_LOAD;
        else                    state_nxt = S_IDLE;
      end
      S_INIT:  state_nxt = S_RUN;
      S_RUN:   if (cnt_last_c) state_nxt = S_DRAIN;
      S_DRAIN: if (cnt_last_c) state_nxt = fifo_empty_c ? S_IDLE : S_LOAD;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output decode; values are registered on the edge that enters the next state
  always_comb begin
    mac_init_nxt    = 1'b0;
    addrgen_rst_nxt = 1'b0;
    busy_nxt        = 1'b0;
    done_nxt        = 1'b0;
    mac_init_nxt    = (state_nxt == S_INIT);
    addrgen_rst_nxt = (state_nxt == S_IDLE);
    busy_nxt        = (state_nxt != S_IDLE);
    done_nxt        = (state_nxt == S_IDLE) && (go || (state != S_IDLE));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mac_init        <= 1'b0;
      mac_addrgen_rst <= 1'b1;
      busy            <= 1'b0;
      done            <= 1'b0;
    end else begin
      mac_init        <= mac_init_nxt;
      mac_addrgen_rst <= addrgen_rst_nxt;
      busy            <= busy_nxt;
      done            <= done_nxt;
    end
  end

  // Shared run/drain down-counter
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      unique case (state)
        S_INIT:  cnt <= run_len_c;
        S_RUN:   cnt <= cnt_last_c ? RUN_W'(PIPE_LAT) : cnt - RUN_W'(1);
        S_DRAIN: cnt <= cnt - RUN_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // FIFO storage (contents need no reset; pointers define validity)
  always_ff @(posedge clk) begin
    if (push_c) mem[wr_ptr] <= cfg_data;
  end

  always_comb begin
    count_nxt = n_pending;
    unique case ({push_c, pop_c})
      2'b10:   count_nxt = n_pending + CNT_W'(1);
      2'b01:   count_nxt = n_pending - CNT_W'(1);
      default: count_nxt = n_pending;
    endcase
  end

  // FIFO pointers, occupancy, ready and the registered MAC config
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      n_pending <= '0;
      cfg_ready <= 1'b1;
      mac_conf  <= '0;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_c) begin
        rd_ptr   <= rd_ptr + PTR_W'(1);
        mac_conf <= mem[rd_ptr];
      end
      n_pending <= count_nxt;
      cfg_ready <= (count_nxt != CNT_W'(DEPTH));
    end
  end

endmodule

// File: tb/tb_xmuladdlite_seq.sv
// Directed self-checking bench for xmuladdlite_seq with hand-computed timing.
module tb_xmuladdlite_seq;

  localparam int unsigned CONF_W = 43;

  logic              clk = 1'b0;
  logic              rst;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [CONF_W-1:0] cfg_data;
  logic              go;
  logic [CONF_W-1:0] mac_conf;
  logic              mac_init;
  logic              mac_addrgen_rst;
  logic              busy;
  logic              done;
  logic [2:0]        n_pending;

  int n_checks = 0;
  int n_errors = 0;
  int cyc, inits, dones;
  logic [CONF_W-1:0] w [5];
  logic [CONF_W-1:0] wa, wb, wc;

  xmuladdlite_seq dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_data(cfg_data), .go(go), .mac_conf(mac_conf), .mac_init(mac_init),
    .mac_addrgen_rst(mac_addrgen_rst), .busy(busy), .done(done), .n_pending(n_pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [CONF_W-1:0] mk(input logic [4:0] sela, input logic [9:0] iter,
                                           input logic [4:0] per, input logic [4:0] dly);
    mk = {sela, 5'h11, 5'h02, iter, per, dly, 5'h07, 3'b101};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (mac_init) inits++;
    if (done) dones++;
  endtask

  task automatic clr();
    cyc = 0; inits = 0; dones = 0;
  endtask

  task automatic wait_done(input int limit);
    while (!done && cyc < limit) tick();
  endtask

  task automatic push(input logic [CONF_W-1:0] d);
    cfg_data = d; cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic pulse_go();
    go = 1'b1;
    tick();
    go = 1'b0;
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_ready"},   64'(cfg_ready), 64'd1);
    check({pfx, "_conf"},    64'(mac_conf), 64'd0);
    check({pfx, "_init"},    64'(mac_init), 64'd0);
    check({pfx, "_agrst"},   64'(mac_addrgen_rst), 64'd1);
    check({pfx, "_busy"},    64'(busy), 64'd0);
    check({pfx, "_done"},    64'(done), 64'd0);
    check({pfx, "_pending"}, 64'(n_pending), 64'd0);
  endtask

  initial begin
    rst = 1'b1; cfg_valid = 1'b0; cfg_data = '0; go = 1'b0;
    clr();
    tick(); tick();
    rst = 1'b0;
    check_reset_outputs("rst");

    // 1: single word, run = 3 + 4*2 = 11, total 1+1+11+6 = 19 cycles from LOAD
    wa = mk(5'd3, 10'd4, 5'd2, 5'd3);
    push(wa);
    check("t1_pending", 64'(n_pending), 64'd1);
    pulse_go();
    clr();
    check("t1_load_busy",  64'(busy), 64'd1);
    check("t1_load_agrst", 64'(mac_addrgen_rst), 64'd0);
    check("t1_load_conf",  64'(mac_conf), 64'(wa));
    check("t1_load_init",  64'(mac_init), 64'd0);
    check("t1_load_pend",  64'(n_pending), 64'd0);
    tick();
    check("t1_init", 64'(mac_init), 64'd1);
    wait_done(60);
    check("t1_done",      64'(done), 64'd1);
    check("t1_cycles",    64'(cyc), 64'd19);
    check("t1_inits",     64'(inits), 64'd1);
    check("t1_busy_drop", 64'(busy), 64'd0);
    check("t1_agrst",     64'(mac_addrgen_rst), 64'd1);
    tick();
    check("t1_done_pulse", 64'(done), 64'd0);

    // 2: DEPTH+1 pushes; each word iter=1 period=0 delay=0 -> 9 cycles
    for (int i = 0; i < 5; i++) w[i] = mk(5'(i + 1), 10'd1, 5'd0, 5'd0);
    cfg_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cfg_data = w[i];
      tick();
    end
    check("t2_full_pend",  64'(n_pending), 64'd4);
    check("t2_full_ready", 64'(cfg_ready), 64'd0);
    cfg_data = w[4];
    tick(); tick();
    check("t2_held_pend", 64'(n_pending), 64'd4);
    go = 1'b1;
    tick();
    go = 1'b0;
    clr();
    check("t2_load_pend",  64'(n_pending), 64'd3);
    check("t2_load_ready", 64'(cfg_ready), 64'd1);
    check("t2_load_conf",  64'(mac_conf), 64'(w[0]));
    tick();
    cfg_valid = 1'b0;
    check("t2_accept_pend",  64'(n_pending), 64'd4);
    check("t2_accept_ready", 64'(cfg_ready), 64'd0);
    wait_done(100);
    check("t2_cycles", 64'(cyc), 64'd45);
    check("t2_inits",  64'(inits), 64'd5);
    check("t2_last",   64'(mac_conf), 64'(w[4]));
    tick();

    // 3: skip, run 1 cycle, skip -> 1+1+1+1+6+1 = 11 cycles, one init
    wa = mk(5'd7, 10'd0, 5'd3, 5'd2);
    wb = mk(5'd8, 10'd1, 5'd0, 5'd0);
    wc = mk(5'd9, 10'd0, 5'd1, 5'd1);
    push(wa); push(wb); push(wc);
    pulse_go();
    clr();
    check("t3_conf0", 64'(mac_conf), 64'(wa));
    tick();
    check("t3_conf1", 64'(mac_conf), 64'(wb));
    wait_done(60);
    check("t3_cycles", 64'(cyc), 64'd11);
    check("t3_inits",  64'(inits), 64'd1);
    check("t3_last",   64'(mac_conf), 64'(wc));
    tick();

    // 4: go on empty queue
    pulse_go();
    check("t4_done",  64'(done), 64'd1);
    check("t4_busy",  64'(busy), 64'd0);
    check("t4_agrst", 64'(mac_addrgen_rst), 64'd1);
    tick();
    check("t4_done_clr", 64'(done), 64'd0);
    check("t4_busy2",    64'(busy), 64'd0);

    // 5: reset while in RUN with 2 words queued
    wa = mk(5'd1, 10'd4, 5'd2, 5'd3);
    push(wa); push(wa); push(wa);
    pulse_go();
    tick(); tick(); tick();
    check("t5_run_busy", 64'(busy), 64'd1);
    check("t5_run_pend", 64'(n_pending), 64'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_outputs("t5");
    clr();
    for (int i = 0; i < 25; i++) tick();
    check("t5_no_done", 64'(dones), 64'd0);
    pulse_go();
    clr();
    for (int i = 0; i < 25; i++) begin
      tick();
      if (busy) inits += 100;
    end
    check("t5_go_idle", 64'(inits), 64'd0);

    // 6: push during DRAIN of last word -> no intermediate done
    wa = mk(5'd4, 10'd1, 5'd0, 5'd0);   // 1+1+1+6 = 9 cycles
    wb = mk(5'd5, 10'd2, 5'd1, 5'd1);   // run 1+2 = 3 -> 11 cycles
    push(wa);
    pulse_go();
    clr();
    tick(); tick(); tick(); tick();
    check("t6_drain_busy", 64'(busy), 64'd1);
    push(wb);
    check("t6_pend", 64'(n_pending), 64'd1);
    wait_done(100);
    check("t6_cycles", 64'(cyc), 64'd20);
    check("t6_inits",  64'(inits), 64'd2);
    check("t6_dones",  64'(dones), 64'd1);
    check("t6_conf",   64'(mac_conf), 64'(wb));
    tick();
    check("t6_idle", 64'(busy), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
